bubble_sort_engine: RTL and testbench

// Parametrised in-place bubble sort accelerator for the PS-attached sorting IP.
// - Host loads N words into internal dual-port RAM, pulses start, and reads the sorted result back as a valid/ready stream.
// - Replaces the fixed 32-bit/1024-entry core; adds runtime order and signedness, early exit, error flag, swap statistics.

---
 rtl/bubble_sort_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_bubble_sort_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort accelerator: host loads words into an internal dual-port RAM,
// pulses start, and drains the sorted result as a valid/ready stream.
module bubble_sort_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    input  logic              descending,
    input  logic              is_signed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  swap_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        CMP      = 3'd2,
        PASS_END = 3'd3,
        STREAM   = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int                DEPTH_I  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_Z  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_Z   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_Z    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_Z   = {DATA_W{1'b0}};

    // a/b are the elements at i and i+1; true when they must be exchanged
    function automatic logic outOfOrder(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic desc,
                                        input logic sgn);
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH_I];
    logic [DATA_W-1:0] rdA_r, rdB_r;

    state_t            state_r, stateNext_s;
    logic [ADDR_W-1:0] i_r, iNext_s, bound_r, boundNext_s, nLast_r, nLastNext_s;
    logic [ADDR_W-1:0] streamIdx_r, streamIdxNext_s, iPlusOne_s;
    logic [1:0]        streamPh_r, streamPhNext_s;
    logic              swapped_r, swappedNext_s, desc_r, descNext_s, sgn_r, sgnNext_s;
    logic              busy_r, busyNext_s, done_r, doneNext_s, error_r, errorNext_s;
    logic              outValid_r, outValidNext_s;
    logic [DATA_W-1:0] outData_r, outDataNext_s;
    logic [CNT_W-1:0]  swapCnt_r, swapCntNext_s;

    logic              weA_s, weB_s;
    logic [ADDR_W-1:0] addrA_s, addrB_s;
    logic [DATA_W-1:0] wdA_s, wdB_s;

    assign iPlusOne_s = i_r + ADDR_ONE;

    // RAM: two write ports and two synchronous read ports, contents untouched by reset
    always_ff @(posedge clk) begin
        if (weA_s) mem[addrA_s] <= wdA_s;
        if (weB_s) mem[addrB_s] <= wdB_s;
        rdA_r <= mem[addrA_s];
        rdB_r <= mem[addrB_s];
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            i_r         <= ADDR_Z;
            bound_r     <= ADDR_Z;
            nLast_r     <= ADDR_Z;
            streamIdx_r <= ADDR_Z;
            streamPh_r  <= 2'd0;
            swapped_r   <= 1'b0;
            desc_r      <= 1'b0;
            sgn_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            outValid_r  <= 1'b0;
            outData_r   <= DATA_Z;
            swapCnt_r   <= CNT_Z;
        end else begin
            state_r     <= stateNext_s;
            i_r         <= iNext_s;
            bound_r     <= boundNext_s;
            nLast_r     <= nLastNext_s;
            streamIdx_r <= streamIdxNext_s;
            streamPh_r  <= streamPhNext_s;
            swapped_r   <= swappedNext_s;
            desc_r      <= descNext_s;
            sgn_r       <= sgnNext_s;
            busy_r      <= busyNext_s;
            done_r      <= doneNext_s;
            error_r     <= errorNext_s;
            outValid_r  <= outValidNext_s;
            outData_r   <= outDataNext_s;
            swapCnt_r   <= swapCntNext_s;
        end
    end

    // next-state, RAM port steering and next output values
    always_comb begin
        stateNext_s     = state_r;
        iNext_s         = i_r;
        boundNext_s     = bound_r;
        nLastNext_s     = nLast_r;
        streamIdxNext_s = streamIdx_r;
        streamPhNext_s  = streamPh_r;
        swappedNext_s   = swapped_r;
        descNext_s      = desc_r;
        sgnNext_s       = sgn_r;
        busyNext_s      = busy_r;
        doneNext_s      = 1'b0;
        errorNext_s     = 1'b0;
        outValidNext_s  = outValid_r;
        outDataNext_s   = outData_r;
        swapCntNext_s   = swapCnt_r;
        weA_s           = 1'b0;
        weB_s           = 1'b0;
        addrA_s         = i_r;
        addrB_s         = iPlusOne_s;
        wdA_s           = rdB_r;
        wdB_s           = rdA_r;

        case (state_r)
            IDLE: begin
                weA_s   = wr_en;
                addrA_s = wr_addr;
                wdA_s   = wr_data;
                if (start) begin
                    if (count > DEPTH_C) begin
                        errorNext_s = 1'b1;
                    end else if (count == COUNT_Z) begin
                        busyNext_s  = 1'b1;
                        stateNext_s = DONE;
                    end else begin
                        nLastNext_s   = count[ADDR_W-1:0] - ADDR_ONE;
                        boundNext_s   = count[ADDR_W-1:0] - ADDR_ONE;
                        iNext_s       = ADDR_Z;
                        swappedNext_s = 1'b0;
                        swapCntNext_s = CNT_Z;
                        descNext_s    = descending;
                        sgnNext_s     = is_signed;
                        busyNext_s    = 1'b1;
                        stateNext_s   = READ;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            READ: begin
                if (bound_r == ADDR_Z) begin
                    streamIdxNext_s = ADDR_Z;
                    streamPhNext_s  = 2'd0;
                    stateNext_s     = STREAM;
                end else begin
                    stateNext_s = CMP;
                end
            end
            CMP: begin
                if (outOfOrder(rdA_r, rdB_r, desc_r, sgn_r)) begin
                    weA_s         = 1'b1;
                    weB_s         = 1'b1;
                    swappedNext_s = 1'b1;
                    swapCntNext_s = (swapCnt_r == CNT_MAX) ? swapCnt_r : swapCnt_r + CNT_ONE;
                end else begin
                    weA_s = 1'b0;
                end
                iNext_s     = iPlusOne_s;
                stateNext_s = (iPlusOne_s == bound_r) ? PASS_END : READ;
            end
            PASS_END: begin
                if (!swapped_r) begin
                    streamIdxNext_s = ADDR_Z;
                    streamPhNext_s  = 2'd0;
                    stateNext_s     = STREAM;
                end else begin
                    boundNext_s   = bound_r - ADDR_ONE;
                    iNext_s       = ADDR_Z;
                    swappedNext_s = 1'b0;
                    stateNext_s   = READ;
                end
            end
            STREAM: begin
                // each beat: issue read, capture data, hold until accepted
                addrA_s = streamIdx_r;
                case (streamPh_r)
                    2'd0: streamPhNext_s = 2'd1;
                    2'd1: begin
                        outDataNext_s  = rdA_r;
                        outValidNext_s = 1'b1;
                        streamPhNext_s = 2'd2;
                    end
                    2'd2: begin
                        if (out_ready) begin
                            outValidNext_s = 1'b0;
                            streamPhNext_s = 2'd0;
                            if (streamIdx_r == nLast_r) begin
                                stateNext_s = DONE;
                            end else begin
                                streamIdxNext_s = streamIdx_r + ADDR_ONE;
                            end
                        end else begin
                            outValidNext_s = 1'b1;
                        end
                    end
                    default: streamPhNext_s = 2'd0;
                endcase
            end
            DONE: begin
                doneNext_s  = 1'b1;
                busyNext_s  = 1'b0;
                stateNext_s = IDLE;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign out_valid  = outValid_r;
    assign out_data   = outData_r;
    assign swap_count = swapCnt_r;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed self-checking bench for bubble_sort_engine: ordering modes, early exit,
// count boundaries, backpressure, and reset/write behaviour while busy.
module tb_bubble_sort_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [10:0] count;
    logic        descending;
    logic        is_signed;
    logic        busy, done, error, out_valid, out_ready;
    logic [31:0] out_data;
    logic [19:0] swap_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] vec  [0:7];
    logic [31:0] expv [0:7];

    bubble_sort_engine dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .count(count), .descending(descending), .is_signed(is_signed),
        .busy(busy), .done(done), .error(error), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadVec(input int n);
        for (int k = 0; k < n; k++) begin
            wr_en = 1'b1; wr_addr = 10'(k); wr_data = vec[k];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic startSort(input int n, input logic desc, input logic sgn);
        count = 11'(n); descending = desc; is_signed = sgn; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // drains n beats, checks order, hold-under-backpressure, done pulse and swap count
    task automatic drain(input int n, input bit rnd, input int expSwaps, input string name);
        int got = 0;
        int cyc = 0;
        bit holding = 1'b0;
        logic [31:0] held = 32'd0;
        while (got < n && cyc < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (holding) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b data=%h required valid=1 data=%h", name, out_valid, out_data, held);
                end
            end
            holding = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    checks++;
                    if (out_data !== expv[got]) begin
                        errors++;
                        $display("FAIL %s_beat%0d: got %h required %h", name, got, out_data, expv[got]);
                    end
                    got++;
                end else begin
                    holding = 1'b1;
                    held = out_data;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_beats: got %0d beats required %0d", name, got, n);
        end
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_post: done=%b valid=%b required 0 0", name, done, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b required 1 0", name, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%b required 0", name, done);
        end
        checks++;
        if (swap_count !== 20'(expSwaps)) begin
            errors++;
            $display("FAIL %s_swaps: got %0d required %0d", name, swap_count, expSwaps);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, error, out_valid} !== 4'b0000 || out_data !== 32'd0 || swap_count !== 20'd0) begin
            errors++;
            $display("FAIL reset: busy/done/error/valid=%b data=%h swaps=%0d required 0000 0 0",
                     {busy, done, error, out_valid}, out_data, swap_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ascending();
        vec[0] = 32'd5; vec[1] = 32'd3; vec[2] = 32'd9; vec[3] = 32'd1;
        expv[0] = 32'd1; expv[1] = 32'd3; expv[2] = 32'd5; expv[3] = 32'd9;
        loadVec(4);
        startSort(4, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL asc_busy: busy=%b required 1", busy);
        end
        drain(4, 1'b0, 4, "asc");
    endtask

    task automatic test_signed();
        vec[0] = 32'hFFFF_FFFF; vec[1] = 32'd2; vec[2] = 32'h8000_0000;
        expv[0] = 32'h8000_0000; expv[1] = 32'hFFFF_FFFF; expv[2] = 32'd2;
        loadVec(3);
        startSort(3, 1'b0, 1'b1);
        drain(3, 1'b0, 2, "signed");
        expv[0] = 32'd2; expv[1] = 32'h8000_0000; expv[2] = 32'hFFFF_FFFF;
        loadVec(3);
        startSort(3, 1'b0, 1'b0);
        drain(3, 1'b0, 2, "unsigned");
    endtask

    task automatic test_early_exit();
        int cyc = 0;
        for (int k = 0; k < 5; k++) begin
            vec[k] = 32'(k + 1);
            expv[k] = 32'(k + 1);
        end
        loadVec(5);
        startSort(5, 1'b0, 1'b0);
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_exit: no output within %0d cycles, required <=20", cyc);
        end
        drain(5, 1'b0, 0, "sorted");
    endtask

    task automatic test_descending_backpressure();
        vec[0] = 32'd4; vec[1] = 32'd4; vec[2] = 32'd7; vec[3] = 32'd1;
        expv[0] = 32'd7; expv[1] = 32'd4; expv[2] = 32'd4; expv[3] = 32'd1;
        loadVec(4);
        startSort(4, 1'b1, 1'b0);
        // host writes and a second start while busy must be ignored
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 32'hDEAD_BEEF; start = 1'b1; count = 11'd0;
        tick(); tick(); tick();
        wr_en = 1'b0; start = 1'b0;
        drain(4, 1'b1, 2, "desc");
    endtask

    task automatic test_count_edges();
        startSort(0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_early: done=%b valid=%b required 0 0", done, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b valid=%b required 1 0", done, out_valid);
        end
        tick();
        startSort(1025, 1'b0, 1'b0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err: error=%b busy=%b required 1 0", error, busy);
        end
        tick();
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse: error=%b busy=%b required 0 0", error, busy);
        end
        vec[0] = 32'd42; expv[0] = 32'd42;
        loadVec(1);
        startSort(1, 1'b0, 1'b0);
        drain(1, 1'b0, 0, "single");
    endtask

    task automatic test_reset_mid_sort();
        vec[0] = 32'd5; vec[1] = 32'd3; vec[2] = 32'd9; vec[3] = 32'd1;
        loadVec(4);
        startSort(4, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || swap_count !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b swaps=%0d required 0 0 0", busy, out_valid, swap_count);
        end
        reset = 1'b0;
        tick();
        vec[0] = 32'd2; vec[1] = 32'd1;
        expv[0] = 32'd1; expv[1] = 32'd2;
        loadVec(2);
        startSort(2, 1'b0, 1'b0);
        drain(2, 1'b0, 1, "recover");
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 10'd0; wr_data = 32'd0; start = 1'b0;
        count = 11'd0; descending = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
        test_reset();
        test_ascending();
        test_signed();
        test_early_exit();
        test_descending_backpressure();
        test_count_edges();
        test_reset_mid_sort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
